// File: rtl/loop_activity_monitor.sv
// Passive profiler for an HLS module and one pipelined loop: saturating invocation, latency,
// iteration, in-flight and stall counters, frozen by a sticky finish. Optional min/max latency: LOOP_MON_LATENCY_EN.
module loop_activity_monitor #(
  parameter int STATE_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               loop_start,
  input  logic               loop_done,
  input  logic               finish,
  output logic               busy,
  output logic               frozen,
  output logic [CNT_W-1:0]   start_cnt,
  output logic [CNT_W-1:0]   done_cnt,
  output logic [CNT_W-1:0]   last_latency,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   max_inflight,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   min_latency,
  output logic [CNT_W-1:0]   max_latency
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   infl_nxt;
  logic [CNT_W-1:0]   lat_now;
  logic               loop_active;
  logic               issue, retire, stall;
  logic               done_ev, start_ev, complete;

  // Handshake readiness does not affect the invocation FSM.
  logic unused_ready;
  assign unused_ready = ap_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign issue  = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign retire = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign stall  = loop_active && (cur_state == iter_start_state) && iter_start_block;

  assign done_ev  = ap_done && ap_continue;
  assign complete = done_ev && ((state == BUSY) || ap_start);
  assign start_ev = ap_start && ((state == IDLE) || done_ev);
  // Latency includes the done cycle; a start-and-done in one idle cycle is latency 1.
  assign lat_now  = (state == BUSY) ? sat_inc(timer) : CNT_W'(1);
  assign busy     = (state == BUSY);

  always_comb begin
    infl_nxt = inflight;
    if (issue && !retire)
      infl_nxt = sat_inc(inflight);
    else if (retire && !issue && (inflight != '0))
      infl_nxt = inflight - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      frozen         <= 1'b0;
      loop_active    <= 1'b0;
      timer          <= '0;
      inflight       <= '0;
      start_cnt      <= '0;
      done_cnt       <= '0;
      last_latency   <= '0;
      iter_start_cnt <= '0;
      iter_end_cnt   <= '0;
      max_inflight   <= '0;
      stall_cnt      <= '0;
    end else begin
      if (finish)
        frozen <= 1'b1;
      loop_active <= (loop_active || loop_start) && !loop_done;

      case (state)
        IDLE:    if (ap_start && !done_ev) state <= BUSY;
        BUSY:    if (done_ev && !ap_start) state <= IDLE;
        default: state <= IDLE;
      endcase

      // frozen is the registered flag, so events in the finish cycle still count.
      if (!frozen) begin
        if (start_ev)
          timer <= CNT_W'(1);
        else if (state == BUSY)
          timer <= sat_inc(timer);

        if (start_ev) start_cnt <= sat_inc(start_cnt);
        if (complete) begin
          done_cnt     <= sat_inc(done_cnt);
          last_latency <= lat_now;
        end

        if (issue)  iter_start_cnt <= sat_inc(iter_start_cnt);
        if (retire) iter_end_cnt   <= sat_inc(iter_end_cnt);
        if (stall)  stall_cnt      <= sat_inc(stall_cnt);

        inflight <= infl_nxt;
        if (infl_nxt > max_inflight)
          max_inflight <= infl_nxt;
      end
    end
  end

`ifdef LOOP_MON_LATENCY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      min_latency <= '0;
      max_latency <= '0;
    end else if (complete && !frozen) begin
      // done_cnt is still zero on the first completion, so seed the minimum from it.
      if ((done_cnt == '0) || (lat_now < min_latency))
        min_latency <= lat_now;
      if (lat_now > max_latency)
        max_latency <= lat_now;
    end
  end
`else
  assign min_latency = '0;
  assign max_latency = '0;
`endif

endmodule

// File: tb/tb_loop_activity_monitor.sv
// Directed bench for loop_activity_monitor: table-driven invocation FSM vectors plus
// hand sequences for pipeline, stall, freeze, reset and saturation corners.
module tb_loop_activity_monitor;

  logic       clock = 1'b0;
  logic       reset, rst4;
  logic       ap_start, ap_ready, ap_done, ap_continue;
  logic [7:0] cur_state, iter_start_state, iter_end_state;
  logic       iter_start_block, iter_end_block, iter_start_enable, iter_end_enable;
  logic       loop_start, loop_done, finish;

  logic        busy, frozen;
  logic [31:0] start_cnt, done_cnt, last_latency, iter_start_cnt, iter_end_cnt;
  logic [31:0] max_inflight, stall_cnt, min_latency, max_latency;

  logic       busy4, frozen4;
  logic [3:0] start_cnt4, done_cnt4, last_latency4, iter_start_cnt4, iter_end_cnt4;
  logic [3:0] max_inflight4, stall_cnt4, min_latency4, max_latency4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  loop_activity_monitor #(.STATE_W(8), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_start(loop_start), .loop_done(loop_done), .finish(finish),
    .busy(busy), .frozen(frozen), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .last_latency(last_latency), .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .max_inflight(max_inflight), .stall_cnt(stall_cnt),
    .min_latency(min_latency), .max_latency(max_latency)
  );

  loop_activity_monitor #(.STATE_W(8), .CNT_W(4)) dut4 (
    .clock(clock), .reset(rst4),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_start(loop_start), .loop_done(loop_done), .finish(finish),
    .busy(busy4), .frozen(frozen4), .start_cnt(start_cnt4), .done_cnt(done_cnt4),
    .last_latency(last_latency4), .iter_start_cnt(iter_start_cnt4), .iter_end_cnt(iter_end_cnt4),
    .max_inflight(max_inflight4), .stall_cnt(stall_cnt4),
    .min_latency(min_latency4), .max_latency(max_latency4)
  );

  typedef struct {
    logic        start, done, cont, ready;
    logic        exp_busy;
    logic [31:0] exp_start, exp_done, exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
    cur_state = 0; iter_start_state = 1; iter_end_state = 2;
    iter_start_block = 0; iter_end_block = 0; iter_start_enable = 0; iter_end_enable = 0;
    loop_start = 0; loop_done = 0; finish = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; rst4 = 1;
    for (int i = 0; i < 3; i++) begin
      {ap_start, ap_ready, ap_done, ap_continue} = 4'($urandom);
      {iter_start_block, iter_end_block, iter_start_enable, iter_end_enable} = 4'($urandom);
      {loop_start, loop_done, finish} = 3'($urandom);
      cur_state = 8'($urandom); iter_start_state = 8'($urandom); iter_end_state = 8'($urandom);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1; rst4 = 1;

    // Reset with random inputs: everything zero.
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_start_cnt", start_cnt, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_last_latency", last_latency, 0);
    chk("rst_iter_start", iter_start_cnt, 0);
    chk("rst_iter_end", iter_end_cnt, 0);
    chk("rst_max_inflight", max_inflight, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_min_lat", min_latency, 0);
    chk("rst_max_lat", max_latency, 0);
    reset = 0; rst4 = 0;

    // Invocation FSM table: {start, done, continue, ready} -> {busy, start_cnt, done_cnt, last_latency}
    vecs[0]  = '{1, 0, 1, 0, 1, 1, 0, 0};
    vecs[1]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 0, 0, 1, 1, 6};
    vecs[6]  = '{0, 0, 1, 0, 0, 1, 1, 6};
    vecs[7]  = '{1, 1, 1, 0, 0, 2, 2, 1};
    vecs[8]  = '{0, 1, 1, 0, 0, 2, 2, 1};
    vecs[9]  = '{1, 0, 1, 0, 1, 3, 2, 1};
    vecs[10] = '{0, 0, 1, 0, 1, 3, 2, 1};
    vecs[11] = '{0, 1, 0, 0, 1, 3, 2, 1};
    vecs[12] = '{1, 1, 1, 0, 1, 4, 3, 4};
    vecs[13] = '{0, 1, 1, 0, 0, 4, 4, 2};
    vecs[14] = '{0, 0, 1, 1, 0, 4, 4, 2};
    for (int i = 0; i < 15; i++) begin
      ap_start = vecs[i].start; ap_done = vecs[i].done;
      ap_continue = vecs[i].cont; ap_ready = vecs[i].ready;
      tick();
      chk($sformatf("fsm%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("fsm%0d_start_cnt", i), start_cnt, vecs[i].exp_start);
      chk($sformatf("fsm%0d_done_cnt", i), done_cnt, vecs[i].exp_done);
      chk($sformatf("fsm%0d_last_latency", i), last_latency, vecs[i].exp_lat);
    end
    idle_inputs();
`ifdef LOOP_MON_LATENCY_EN
    chk("min_latency", min_latency, 1);
    chk("max_latency", max_latency, 6);
`else
    chk("min_latency_off", min_latency, 0);
    chk("max_latency_off", max_latency, 0);
`endif

    // Pipeline: 10 issues, retires lagging 2 cycles, single-state II=1 loop.
    do_reset(); reset = 0; rst4 = 0;
    iter_start_state = 3; iter_end_state = 3; cur_state = 3;
    for (int k = 0; k < 12; k++) begin
      iter_start_enable = (k < 10);
      iter_end_enable   = (k >= 2);
      tick();
    end
    iter_start_enable = 0; iter_end_enable = 0;
    chk("pipe_iter_start", iter_start_cnt, 10);
    chk("pipe_iter_end", iter_end_cnt, 10);
    chk("pipe_max_inflight", max_inflight, 2);
    chk("pipe_stall", stall_cnt, 0);
    // Spurious retire at zero in-flight must not underflow; 3 issues then peak at 3.
    iter_end_enable = 1; tick(); iter_end_enable = 0;
    iter_start_enable = 1; repeat (3) tick(); iter_start_enable = 0;
    chk("pipe_floor_max_inflight", max_inflight, 3);
    chk("pipe_iter_start2", iter_start_cnt, 13);

    // Stall: 4 blocked cycles inside an active loop, then 2 after loop_done.
    do_reset(); reset = 0; rst4 = 0;
    iter_start_state = 5; iter_end_state = 6;
    loop_start = 1; tick(); loop_start = 0;
    cur_state = 5; iter_start_enable = 1; iter_start_block = 1;
    repeat (4) tick();
    chk("stall_cnt", stall_cnt, 4);
    chk("stall_no_issue", iter_start_cnt, 0);
    cur_state = 0; loop_done = 1; tick(); loop_done = 0;
    cur_state = 5; repeat (2) tick();
    chk("stall_inactive", stall_cnt, 4);
    idle_inputs();

    // Freeze: events in the finish cycle count, later ones do not.
    do_reset(); reset = 0; rst4 = 0;
    ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; tick(); ap_done = 0;
    chk("frz_pre_latency", last_latency, 2);
    ap_start = 1; ap_done = 1; finish = 1; tick();
    ap_start = 0; ap_done = 0; finish = 0;
    chk("frz_frozen", 32'(frozen), 1);
    chk("frz_start_cnt_fin", start_cnt, 2);
    chk("frz_latency_fin", last_latency, 1);
    for (int p = 0; p < 3; p++) begin
      ap_start = 1; tick(); ap_start = 0;
      ap_done = 1; tick(); ap_done = 0;
    end
    iter_start_state = 0; iter_start_enable = 1; tick(); iter_start_enable = 0;
    chk("frz_start_cnt", start_cnt, 2);
    chk("frz_done_cnt", done_cnt, 2);
    chk("frz_latency", last_latency, 1);
    chk("frz_iter_start", iter_start_cnt, 0);
    chk("frz_sticky", 32'(frozen), 1);
    do_reset(); reset = 0; rst4 = 0;
    chk("frz_reset_frozen", 32'(frozen), 0);
    chk("frz_reset_start_cnt", start_cnt, 0);
    chk("frz_reset_done_cnt", done_cnt, 0);

    // Reset mid-invocation: next start counted fresh with fresh timer.
    ap_start = 1; tick(); ap_start = 0; tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("midrst_busy", 32'(busy), 0);
    ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; tick(); ap_done = 0;
    chk("midrst_start_cnt", start_cnt, 1);
    chk("midrst_latency", last_latency, 2);

    // Saturation on the 4-bit instance: 20 issues, no retires.
    do_reset(); reset = 0; rst4 = 0;
    iter_start_state = 7; iter_end_state = 8; cur_state = 7; iter_start_enable = 1;
    repeat (20) tick();
    idle_inputs();
    chk("sat_iter_start4", 32'(iter_start_cnt4), 15);
    chk("sat_max_inflight4", 32'(max_inflight4), 15);
    chk("sat_iter_start32", iter_start_cnt, 20);
    chk("sat_frozen4", 32'(frozen4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
